chunked_add_sub: RTL and testbench

CHUNKED_ADD_SUB -- requirements
Module: chunked_add_sub

---
 rtl/add_sub_pkg.sv | 13 +
 rtl/chunk_adder.sv | 30 +++
 rtl/full_adder.sv | 13 +
 rtl/chunked_add_sub.sv | 127 ++++++++++++
 tb/tb_chunked_add_sub.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and op codes.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder built from full_adder cells; also exposes the carry into its MSB.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar g = 0; g < CHUNK; g++) begin : g_fa
        full_adder u_fa (
            .a_i   (a_i[g]),
            .b_i   (b_i[g]),
            .cin_i (c[g]),
            .sum_o (sum_o[g]),
            .cout_o(c[g+1])
        );
    end

    assign cout_o  = c[CHUNK];
    assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per cycle, LSB first, through a shared chunk_adder.
module chunked_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             add_sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and results hold stable until their transfer.

    state_t state_q, state_d;
    logic   accept, step, last;

    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic             carry_q, cout_q, ovf_q, zero_q;
    logic [CW-1:0]    cnt_q;

    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout, ch_cmsb;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .cin_i  (carry_q),
        .sum_o  (ch_sum),
        .cout_o (ch_cout),
        .c_msb_o(ch_cmsb)
    );

    // Result fills from the top so after NCH slices the first chunk sits at the LSB.
    if (NCH == 1) begin : g_res_single
        assign res_d = ch_sum;
    end else begin : g_res_multi
        assign res_d = {ch_sum, res_q[WIDTH-1:CHUNK]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= in1;
            b_q     <= in2 ^ {WIDTH{add_sub}};
            carry_q <= (add_sub == OP_SUB);
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= ch_cout;
            res_q   <= res_d;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                cout_q <= ch_cout;
                ovf_q  <= ch_cout ^ ch_cmsb;
                zero_q <= (res_d == '0);
            end
        end
    end

    assign out       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: directed vector table, randomized ops against an arithmetic model,
// back-pressure, mid-operation reset, and a single-chunk instance.
module tb_chunked_add_sub;
  import add_sub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, add_sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] in1, in2, out;
  logic [1:0]  dbg_state;

  logic        in_valid8, in_ready8, add_sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0]  in18, in28, out8;
  logic [1:0]  dbg_state8;

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .add_sub(add_sub),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .cout(cout), .ovf(ovf), .zero(zero), .dbg_state(dbg_state)
  );

  chunked_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .add_sub(add_sub8),
    .in1(in18), .in2(in28), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
    .cout(cout8), .ovf(ovf8), .zero(zero8), .dbg_state(dbg_state8)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e_out;
    logic        e_cout;
    logic        e_ovf;
    logic        e_zero;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic vec_t ref_op(input logic op, input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    int   ua, ub, sa, sb, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    v.op = op;
    v.a  = a;
    v.b  = b;
    if (op == OP_ADD) begin
      v.e_out  = 16'(ua + ub);
      v.e_cout = (ua + ub) > 65535;
      s        = sa + sb;
    end else begin
      v.e_out  = 16'(ua - ub);
      v.e_cout = (ua >= ub);
      s        = sa - sb;
    end
    v.e_ovf  = (s > 32767) || (s < -32768);
    v.e_zero = (v.e_out == 16'h0000);
    return v;
  endfunction

  // One full transaction on the 16-bit instance; returns outputs and accept-to-valid latency.
  task automatic do_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic co, output logic ov,
                       output logic z, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    add_sub  = op;
    in1      = a;
    in2      = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    add_sub  = 1'($urandom);
    in1      = 16'($urandom);
    in2      = 16'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    r  = out;
    co = cout;
    ov = ovf;
    z  = zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [15:0] r;
    logic        co, ov, z;
    int          lat;
    do_op(v.op, v.a, v.b, r, co, ov, z, lat);
    check({tag, "_out"}, r, v.e_out);
    check({tag, "_cout"}, co, v.e_cout);
    check({tag, "_ovf"}, ov, v.e_ovf);
    check({tag, "_zero"}, z, v.e_zero);
    check({tag, "_latency"}, lat, 4);
  endtask

  initial begin
    logic [15:0] r;
    logic        co, ov, z;
    int          lat, k;
    logic        saw_valid;

    vecs[0] = '{OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; add_sub = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; add_sub8 = 1'b0; in18 = '0; in28 = '0; out_ready8 = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_flags", {cout, ovf, zero}, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_state", dbg_state, IDLE);

    // directed table
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // randomized against the model
    for (int i = 0; i < 30; i++) begin
      logic        op;
      logic [15:0] a, b;
      op = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = (i % 5 == 0) ? a : 16'($urandom);
      run_vec($sformatf("rnd%0d", i), ref_op(op, a, b));
    end

    // back-pressure: result holds while new requests are ignored
    @(negedge clk);
    in_valid = 1'b1; add_sub = OP_ADD; in1 = 16'h1000; in2 = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_valid", out_valid, 1);
    in_valid = 1'b1; add_sub = OP_SUB; in1 = 16'hAAAA; in2 = 16'h5555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_out%0d", c), out, 16'h1001);
      check($sformatf("bp_hold_valid%0d", c), out_valid, 1);
      check($sformatf("bp_in_ready%0d", c), in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", out_valid, 0);
    check("bp_released_state", dbg_state, IDLE);
    check("bp_released_in_ready", in_ready, 1);
    in_valid = 1'b0;
    out_ready = 1'b0;

    // reset after two RUN cycles discards the operation
    @(negedge clk);
    in_valid = 1'b1; add_sub = OP_ADD; in1 = 16'hFFFF; in2 = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready_low", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_state", dbg_state, IDLE);
    check("midrst_out", out, 0);
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    check("midrst_no_result", saw_valid, 0);
    do_op(OP_ADD, 16'h1234, 16'h1111, r, co, ov, z, lat);
    check("midrst_next_out", r, 16'h2345);
    check("midrst_next_latency", lat, 4);

    // single-chunk instance: latency 1
    @(negedge clk);
    in_valid8 = 1'b1; add_sub8 = OP_SUB; in18 = 8'h80; in28 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8_sub_latency1", out_valid8, 0);
    @(negedge clk);
    check("w8_sub_valid", out_valid8, 1);
    check("w8_sub_out", out8, 8'h7F);
    check("w8_sub_ovf", ovf8, 1);
    check("w8_sub_cout", cout8, 1);
    check("w8_sub_zero", zero8, 0);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("w8_sub_release", out_valid8, 0);
    in_valid8 = 1'b1; add_sub8 = OP_ADD; in18 = 8'hFF; in28 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_add_valid", out_valid8, 1);
    check("w8_add_out", out8, 8'h00);
    check("w8_add_flags", {cout8, ovf8, zero8}, 3'b101);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck handshake still ends in a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
